// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  // Tick-phase values at mid-bit (start-bit check) and at the end of a bit period.
  localparam logic [3:0] PHASE_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] PHASE_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks while enabled, held at 0 otherwise.
module uart_baud_tick #(
  parameter int unsigned DIV = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = enable && (cnt == 16'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 16'd0;
    end else if (!enable || tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a one-byte output buffer and
// valid/ready hand-off: a byte transfers when rx_valid && rx_ready at a clk edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 48_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DIV    = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx232,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  uart_rx_state_t state;
  logic [1:0]     sync_q;
  logic           rxs;
  logic           tick;
  logic [3:0]     phase;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;

  // Synchronizer flops reset to the idle level so reset never fakes a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx232};
    end
  end

  assign rxs  = sync_q[1];
  assign busy = (state != ST_IDLE);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (busy),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phase     <= 4'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state   <= ST_START;
            phase   <= 4'd0;
            bit_cnt <= 3'd0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (phase == PHASE_MID) begin
              // Realign phase so every later sample lands mid-bit.
              phase <= 4'd0;
              state <= rxs ? ST_IDLE : ST_DATA;
            end else begin
              phase <= phase + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == PHASE_LAST) begin
              shreg   <= {rxs, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ST_STOP;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            phase <= phase + 4'd1;
            if (phase == PHASE_LAST) begin
              if (rxs) begin
                state <= ST_IDLE;
                // Buffer is free if empty or being drained this very edge.
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_IDLE;
              end
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at DIV=4 (64 clk per bit).
module tb_uart_rx;

  localparam int DIV     = 4;
  localparam int BIT_CLK = 16 * DIV;
  localparam int LAT     = 2 + (8 + 16 * 9) * DIV + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx232 = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx232     (rx232),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int t_start = 0;
  int t_valid = -1;
  int valid_rises = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Reference buffer model: what the consumer should see after each good frame.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_ovr   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      valid_rises++;
      t_valid = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx232 = fr[i];
      if (i == 0) t_start = cyc;
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic ready);
    if (!m_valid || ready) begin
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr++;
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    m_valid  = 1'b0;
  endtask

  initial begin
    int o0, f0, v0, n;
    logic [7:0] b1, b2;

    repeat (3) @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 8'h00);
    check("reset_busy", busy, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte, held until a one-cycle ready
    t_valid = -1;
    send_frame(8'hA5, 1'b1, BIT_CLK);
    model_frame(8'hA5, 1'b0);
    check("latency_window", ((t_valid - t_start) >= LAT - 1) && ((t_valid - t_start) <= LAT + 1), 1);
    check("a5_valid", rx_valid, m_valid);
    check("a5_data", rx_data, m_data);
    repeat (100) @(negedge clk);
    check("a5_held_valid", rx_valid, 1);
    check("a5_held_data", rx_data, 8'hA5);
    consume();
    check("a5_accept_valid", rx_valid, m_valid);
    check("a5_accept_data_hold", rx_data, 8'hA5);
    repeat (10) @(negedge clk);

    // Back-to-back with buffer full: first byte kept, one overrun
    m_ovr = 0;
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1, BIT_CLK);
    model_frame(8'h3C, 1'b0);
    send_frame(8'hC3, 1'b1, BIT_CLK);
    model_frame(8'hC3, 1'b0);
    repeat (20) @(negedge clk);
    check("ovr_data", rx_data, m_data);
    check("ovr_valid", rx_valid, m_valid);
    check("ovr_pulses", ovr_cnt - o0, m_ovr);
    consume();

    // Back-to-back with ready held: both delivered
    rx_ready = 1'b1;
    got_q.delete();
    exp_q = '{8'h3C, 8'hC3};
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1, BIT_CLK);
    send_frame(8'hC3, 1'b1, BIT_CLK);
    repeat (20) @(negedge clk);
    rx_ready = 1'b0;
    check("rdy_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("rdy_byte", got_q[i], exp_q[i]);
    check("rdy_no_ovr", ovr_cnt - o0, 0);
    check("rdy_drained", rx_valid, 0);

    // Short low glitch on idle line
    v0 = valid_rises;
    f0 = ferr_cnt;
    rx232 = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_mid", busy, 1);
    repeat (10) @(negedge clk);
    rx232 = 1'b1;
    repeat (18) @(negedge clk);
    check("glitch_busy_end", busy, 0);
    check("glitch_no_valid", valid_rises - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Stop bit low, then break
    v0 = valid_rises;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, BIT_CLK);
    repeat (300) @(negedge clk);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_no_valid", valid_rises - v0, 0);
    check("break_busy", busy, 1);
    rx232 = 1'b1;
    repeat (6) @(negedge clk);
    check("break_idle", busy, 0);
    send_frame(8'h0F, 1'b1, BIT_CLK);
    repeat (10) @(negedge clk);
    check("after_break_valid", rx_valid, 1);
    check("after_break_data", rx_data, 8'h0F);
    check("after_break_ferr", ferr_cnt - f0, 1);
    consume();

    // Reset in the middle of a frame
    v0 = valid_rises;
    fork
      send_frame(8'hFF, 1'b1, BIT_CLK);
      begin
        repeat (200) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    check("mid_rst_no_valid", valid_rises - v0, 0);
    check("mid_rst_idle", busy, 0);
    send_frame(8'h81, 1'b1, BIT_CLK);
    repeat (10) @(negedge clk);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_data", rx_data, 8'h81);
    consume();

    // Sender rate +/-3 percent
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 66 : 62;
      f0 = ferr_cnt;
      send_frame(8'h96, 1'b1, n);
      repeat (20) @(negedge clk);
      check("skew_valid", rx_valid, 1);
      check("skew_data", rx_data, 8'h96);
      check("skew_no_ferr", ferr_cnt - f0, 0);
      consume();
    end

    // Random bytes at random rates, ready held
    rx_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    f0 = ferr_cnt;
    for (int k = 0; k < 6; k++) begin
      b1 = 8'($urandom_range(0, 255));
      exp_q.push_back(b1);
      send_frame(b1, 1'b1, $urandom_range(62, 66));
      repeat ($urandom_range(5, 30)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    rx_ready = 1'b0;
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("rand_byte", got_q[i], exp_q[i]);
    check("rand_no_ferr", ferr_cnt - f0, 0);

    // Random pair into a full buffer
    m_valid = 1'b0;
    m_ovr = 0;
    o0 = ovr_cnt;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    send_frame(b1, 1'b1, BIT_CLK);
    model_frame(b1, 1'b0);
    send_frame(b2, 1'b1, BIT_CLK);
    model_frame(b2, 1'b0);
    repeat (20) @(negedge clk);
    check("rand_ovr_data", rx_data, m_data);
    check("rand_ovr_valid", rx_valid, m_valid);
    check("rand_ovr_pulses", ovr_cnt - o0, m_ovr);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
